gray_counter: RTL and testbench

//  Parametrised, registered Gray-code counter; successor to the 4-bit combinational bintogray converter.

---
 rtl/gray_pkg.sv | 16 +
 rtl/gray_counter_if.sv | 22 ++
 rtl/gray_codec.sv | 17 +
 rtl/gray_counter.sv | 55 +++++
 tb/tb_gray_counter.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/gray_pkg.sv
// gray_pkg: shared Gray-code conversions, range helper and step operation type
package gray_pkg;
  typedef enum logic [1:0] {OP_HOLD, OP_LOAD, OP_UP, OP_DN} op_e;
  function automatic logic [31:0] max_val(input int w);
    return w >= 32 ? '1 : (32'd1 << w) - 32'd1;
  endfunction
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/gray_counter_if.sv
// gray_counter_if: control and count bundle between a counter user and the counter
interface gray_counter_if #(
  parameter int WIDTH = 4
);
  logic en;
  logic up_dn;
  logic load;
  logic [WIDTH-1:0] load_val;
  logic load_is_gray;
  logic [WIDTH-1:0] bin_o;
  logic [WIDTH-1:0] gray_o;
  logic tc;
  logic wrap_pulse;
  modport master (
    output en, up_dn, load, load_val, load_is_gray,
    input bin_o, gray_o, tc, wrap_pulse
  );
  modport slave (
    input en, up_dn, load, load_val, load_is_gray,
    output bin_o, gray_o, tc, wrap_pulse
  );
endinterface

// File: rtl/gray_codec.sv
// gray_codec: combinational binary-to-Gray encode and Gray-to-binary decode
module gray_codec
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_bin,
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_gray,
  output logic [WIDTH-1:0] o_bin
);
  // both directions are pure bit-wise XOR networks on the zero-extended value
  always_comb begin
    o_gray = WIDTH'(bin2gray(32'(i_bin)));
    o_bin  = WIDTH'(gray2bin(32'(i_gray)));
  end
endmodule

// File: rtl/gray_counter.sv
// gray_counter: registered up/down Gray counter with binary/Gray load, wrap or saturate
module gray_counter
  import gray_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int WRAP      = 1,
  parameter int RESET_VAL = 0
) (
  input logic clk,
  input logic rst_n,
  gray_counter_if.slave bus
);
  localparam logic [WIDTH-1:0] MAX      = WIDTH'(max_val(WIDTH));
  localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] RST_GRAY = WIDTH'(bin2gray(32'(RESET_VAL)));
  localparam bit WRAP_EN = (WRAP != 0);
  logic [WIDTH-1:0] r_bin, r_gray;
  logic r_wrap;
  logic [WIDTH-1:0] w_ld_bin, w_ld_gray, w_step, w_step_gray, w_cur, w_next_bin, w_next_gray;
  logic w_at_end, w_wrap;
  op_e w_op;
  gray_codec #(.WIDTH(WIDTH)) u_ld (
    .i_bin(bus.load_val), .i_gray(bus.load_val), .o_gray(w_ld_gray), .o_bin(w_ld_bin)
  );
  gray_codec #(.WIDTH(WIDTH)) u_out (
    .i_bin(w_step), .i_gray(r_gray), .o_gray(w_step_gray), .o_bin(w_cur)
  );
  // select the operation and build next binary/Gray values; a saturated end holds
  always_comb begin
    w_op = bus.load ? OP_LOAD : !bus.en ? OP_HOLD : bus.up_dn ? OP_UP : OP_DN;
    w_at_end = bus.up_dn ? (r_bin == MAX) : (r_bin == '0);
    w_wrap = (w_op == OP_UP || w_op == OP_DN) && w_at_end && WRAP_EN;
    w_step = (w_at_end && !WRAP_EN) ? r_bin : bus.up_dn ? r_bin + 1'b1 : r_bin - 1'b1;
    w_next_bin = w_op == OP_LOAD ? (bus.load_is_gray ? w_ld_bin : bus.load_val) :
                 w_op == OP_HOLD ? r_bin : w_step;
    w_next_gray = w_op == OP_LOAD ? (bus.load_is_gray ? bus.load_val : w_ld_gray) :
                  w_op == OP_HOLD ? r_gray : w_step_gray;
  end
  // state registers: reset beats load beats count; wrap flag lasts one cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bin  <= RST_BIN;
      r_gray <= RST_GRAY;
      r_wrap <= 1'b0;
    end else begin
      r_bin  <= w_next_bin;
      r_gray <= w_next_gray;
      r_wrap <= w_wrap;
    end
  end
  assign bus.bin_o      = r_bin;
  assign bus.gray_o     = r_gray;
  assign bus.wrap_pulse = r_wrap;
  assign bus.tc         = bus.up_dn ? (w_cur == MAX) : (w_cur == '0);
endmodule

// File: tb/tb_gray_counter.sv
// tb_gray_counter: three counter configurations against an arithmetic reference model
module tb_gray_counter;
  logic clk = 0, rst_n = 0, en = 1, up_dn = 0, load = 1, lig = 0;
  int lv[3] = '{3, 3, 3};
  int m_bin[3] = '{0, 0, 0};
  int m_wp[3] = '{0, 0, 0};
  int m_hd[3] = '{-1, -1, -1};
  int n_tests = 0, n_fail = 0;
  int gseq[17] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};

  gray_counter_if #(.WIDTH(4)) bus_a ();
  gray_counter_if #(.WIDTH(4)) bus_b ();
  gray_counter_if #(.WIDTH(6)) bus_c ();
  assign bus_a.en = en;
  assign bus_a.up_dn = up_dn;
  assign bus_a.load = load;
  assign bus_a.load_is_gray = lig;
  assign bus_a.load_val = 4'(lv[0]);
  assign bus_b.en = en;
  assign bus_b.up_dn = up_dn;
  assign bus_b.load = load;
  assign bus_b.load_is_gray = lig;
  assign bus_b.load_val = 4'(lv[1]);
  assign bus_c.en = en;
  assign bus_c.up_dn = up_dn;
  assign bus_c.load = load;
  assign bus_c.load_is_gray = lig;
  assign bus_c.load_val = 6'(lv[2]);

  gray_counter #(.WIDTH(4), .WRAP(1), .RESET_VAL(0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  gray_counter #(.WIDTH(4), .WRAP(0), .RESET_VAL(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
  gray_counter #(.WIDTH(6), .WRAP(1), .RESET_VAL(5)) dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

  always #5 clk = ~clk;

  function automatic int wd(input int k);
    return k == 2 ? 6 : 4;
  endfunction
  function automatic int wrp(input int k);
    return k == 1 ? 0 : 1;
  endfunction
  function automatic int rv(input int k);
    return k == 2 ? 5 : 0;
  endfunction
  function automatic int g2b(input int g, input int w);
    for (int b = 0; b < (1 << w); b++) if ((b ^ (b >> 1)) == g) return b;
    return 0;
  endfunction
  function automatic int o_bin(input int k);
    return k == 0 ? int'(bus_a.bin_o) : k == 1 ? int'(bus_b.bin_o) : int'(bus_c.bin_o);
  endfunction
  function automatic int o_gray(input int k);
    return k == 0 ? int'(bus_a.gray_o) : k == 1 ? int'(bus_b.gray_o) : int'(bus_c.gray_o);
  endfunction
  function automatic int o_wrap(input int k);
    return k == 0 ? int'(bus_a.wrap_pulse) : k == 1 ? int'(bus_b.wrap_pulse) : int'(bus_c.wrap_pulse);
  endfunction
  function automatic int o_tc(input int k);
    return k == 0 ? int'(bus_a.tc) : k == 1 ? int'(bus_b.tc) : int'(bus_c.tc);
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_next();
    for (int k = 0; k < 3; k++) begin
      int mx, prev;
      mx = (1 << wd(k)) - 1;
      prev = m_bin[k];
      m_wp[k] = 0;
      m_hd[k] = -1;
      if (!rst_n) m_bin[k] = rv(k);
      else if (load) m_bin[k] = lig ? g2b(lv[k] & mx, wd(k)) : (lv[k] & mx);
      else if (en) begin
        if (up_dn) begin
          if (prev < mx) m_bin[k] = prev + 1;
          else if (wrp(k) != 0) begin
            m_bin[k] = 0;
            m_wp[k] = 1;
          end
        end else begin
          if (prev > 0) m_bin[k] = prev - 1;
          else if (wrp(k) != 0) begin
            m_bin[k] = mx;
            m_wp[k] = 1;
          end
        end
        m_hd[k] = (m_bin[k] != prev) ? 1 : 0;
      end
    end
  endtask

  task automatic cycle();
    int pg[3];
    for (int k = 0; k < 3; k++) pg[k] = o_gray(k);
    model_next();
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      int mx;
      mx = (1 << wd(k)) - 1;
      check($sformatf("bin%0d", k), o_bin(k), m_bin[k]);
      check($sformatf("gray%0d", k), o_gray(k), m_bin[k] ^ (m_bin[k] >> 1));
      check($sformatf("wrap%0d", k), o_wrap(k), m_wp[k]);
      check($sformatf("tc%0d", k), o_tc(k), up_dn ? int'(m_bin[k] == mx) : int'(m_bin[k] == 0));
      if (m_hd[k] >= 0) check($sformatf("gray_step%0d", k), $countones(pg[k] ^ o_gray(k)), m_hd[k]);
    end
  endtask

  initial begin
    cycle();
    cycle();
    check("rst_bin", o_bin(0), 0);
    check("rst_gray", o_gray(0), 0);
    check("rst_wrap", o_wrap(0), 0);
    check("rst_tc", o_tc(0), 1);
    check("rst_bin_c", o_bin(2), 5);
    rst_n = 1; load = 0; en = 1; up_dn = 1;
    for (int i = 0; i < 16; i++) begin
      cycle();
      check("seq_gray", o_gray(0), gseq[i+1]);
      check("seq_wrap", o_wrap(0), int'(i == 15));
    end
    up_dn = 0;
    cycle();
    check("dn_wrap_bin", o_bin(0), 15);
    check("dn_wrap_gray", o_gray(0), 8);
    check("dn_wrap_pulse", o_wrap(0), 1);
    cycle();
    check("dn_bin", o_bin(0), 14);
    check("dn_gray", o_gray(0), 9);
    check("dn_pulse", o_wrap(0), 0);
    en = 0; load = 1; lig = 0; lv[0] = 9;
    cycle();
    check("ld_bin", o_bin(0), 9);
    check("ld_gray", o_gray(0), 13);
    lv[0] = 13; lig = 1;
    cycle();
    check("ldg_bin", o_bin(0), 9);
    load = 0; en = 1; up_dn = 1;
    cycle();
    check("pre_ld_bin", o_bin(0), 10);
    load = 1; lig = 0; lv[0] = 9;
    cycle();
    check("ld_en_bin", o_bin(0), 9);
    check("ld_en_wrap", o_wrap(0), 0);
    load = 1; en = 0; lv[1] = 15;
    cycle();
    load = 0; en = 1; up_dn = 1;
    repeat (3) begin
      cycle();
      check("sat_hi_bin", o_bin(1), 15);
      check("sat_hi_tc", o_tc(1), 1);
      check("sat_hi_wrap", o_wrap(1), 0);
    end
    load = 1; en = 0; lv[1] = 0;
    cycle();
    load = 0; en = 1; up_dn = 0;
    cycle();
    check("sat_lo_bin", o_bin(1), 0);
    load = 1; en = 0; lig = 0; lv[2] = 36;
    cycle();
    load = 0; en = 1; up_dn = 1;
    cycle();
    check("mid_bin", o_bin(2), 37);
    rst_n = 0; load = 1;
    cycle();
    check("mid_rst_bin", o_bin(2), 5);
    check("mid_rst_gray", o_gray(2), 7);
    rst_n = 1; load = 0;
    cycle();
    check("resume_bin", o_bin(2), 6);
    check("resume_gray", o_gray(2), 5);
    for (int i = 0; i < 500; i++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      load = ($urandom_range(0, 15) == 0);
      lig = $urandom_range(0, 1) != 0;
      en = ($urandom_range(0, 3) != 0);
      up_dn = $urandom_range(0, 1) != 0;
      for (int k = 0; k < 3; k++) lv[k] = int'($urandom_range(0, 63));
      cycle();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
